// File: rtl/ipsxe_fft_frame_arb.sv
// Frame-granular arbiter sharing one FFT core between two AXI4-Stream sources.
// Define FFT_ARB_FIXED_PRIO_EN to give ch0 fixed priority instead of round-robin.
module ipsxe_fft_frame_arb #(
    parameter int LOG2_FFT_LEN = 4,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  i_aclk,
    input  logic                  i_rst,
    input  logic                  i_aclken,
    input  logic                  i_s0_tvalid,
    output logic                  o_s0_tready,
    input  logic                  i_s0_tlast,
    input  logic [DATA_WIDTH-1:0] i_s0_tdata,
    input  logic                  i_s0_mode,
    input  logic                  i_s1_tvalid,
    output logic                  o_s1_tready,
    input  logic                  i_s1_tlast,
    input  logic [DATA_WIDTH-1:0] i_s1_tdata,
    input  logic                  i_s1_mode,
    output logic                  o_m_tvalid,
    input  logic                  i_m_tready,
    output logic [DATA_WIDTH-1:0] o_m_tdata,
    output logic                  o_m_tlast,
    output logic                  o_cfg_tvalid,
    output logic                  o_cfg_tdata,
    output logic [1:0]            o_grant,
    output logic                  o_frame_err
);

    localparam logic [LOG2_FFT_LEN-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_CFG, ST_XFER} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              grant_q, grant_d;
    logic [LOG2_FFT_LEN-1:0] cnt_q, cnt_d;
    logic                    cfg_tdata_q, cfg_tdata_d;
    logic                    err_q, err_d;
`ifndef FFT_ARB_FIXED_PRIO_EN
    logic                    rr_q, rr_d;   // 1: ch1 preferred on a tie
`endif

    logic                    xfer, sel_valid, sel_last, m_valid, beat, last_beat, pick1;
    logic [DATA_WIDTH-1:0]   sel_data;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        cfg_tdata_d = cfg_tdata_q;
        err_d       = err_q;
`ifndef FFT_ARB_FIXED_PRIO_EN
        rr_d        = rr_q;
`endif
        pick1       = 1'b0;

        xfer      = (state_q == ST_XFER);
        sel_valid = grant_q[1] ? i_s1_tvalid : i_s0_tvalid;
        sel_last  = grant_q[1] ? i_s1_tlast  : i_s0_tlast;
        sel_data  = grant_q[1] ? i_s1_tdata  : i_s0_tdata;
        m_valid   = xfer & sel_valid;
        beat      = m_valid & i_m_tready & i_aclken;
        last_beat = (cnt_q == CNT_LAST);

        o_m_tvalid   = m_valid;
        o_m_tdata    = m_valid ? sel_data : '0;
        o_m_tlast    = xfer & last_beat;
        o_s0_tready  = xfer & grant_q[0] & i_m_tready & i_aclken;
        o_s1_tready  = xfer & grant_q[1] & i_m_tready & i_aclken;
        o_cfg_tvalid = (state_q == ST_CFG);
        o_cfg_tdata  = cfg_tdata_q;
        o_grant      = grant_q;
        o_frame_err  = err_q;

        if (i_aclken) begin
            err_d = beat & (sel_last ^ last_beat);
            unique case (state_q)
                ST_IDLE: begin
                    if (i_s0_tvalid | i_s1_tvalid) begin
`ifdef FFT_ARB_FIXED_PRIO_EN
                        pick1 = i_s1_tvalid & ~i_s0_tvalid;
`else
                        pick1 = i_s1_tvalid & (~i_s0_tvalid | rr_q);
`endif
                        grant_d     = pick1 ? 2'b10 : 2'b01;
                        cfg_tdata_d = pick1 ? i_s1_mode : i_s0_mode;
                        state_d     = ST_CFG;
                    end
                end
                ST_CFG: begin
                    state_d = ST_XFER;
                end
                ST_XFER: begin
                    if (beat) begin
                        cnt_d = cnt_q + 1'b1;
                        if (last_beat) begin
                            grant_d = '0;
                            state_d = ST_IDLE;
`ifndef FFT_ARB_FIXED_PRIO_EN
                            rr_d    = grant_q[0];
`endif
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            cnt_q       <= '0;
            cfg_tdata_q <= 1'b0;
            err_q       <= 1'b0;
`ifndef FFT_ARB_FIXED_PRIO_EN
            rr_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            cfg_tdata_q <= cfg_tdata_d;
            err_q       <= err_d;
`ifndef FFT_ARB_FIXED_PRIO_EN
            rr_q        <= rr_d;
`endif
        end
    end

endmodule
